// File: rtl/wide_arith_pkg.sv
// Shared widths and segment arithmetic for the 96-bit add/subtract datapaths.
// sub_seg_f returns {borrow_out, diff} for a - b - bin on one segment.
package wide_arith_pkg;

    localparam int DATA_W = 96;
    localparam int SEG_W  = 48;

    typedef logic [SEG_W-1:0] seg_t;

    // A 49-bit wrap leaves bit SEG_W set exactly when a < b + bin.
    function automatic logic [SEG_W:0] sub_seg_f(input seg_t a, input seg_t b, input logic bin);
        return {1'b0, a} - {1'b0, b} - {{SEG_W{1'b0}}, bin};
    endfunction

endpackage

// File: rtl/sub_seg.sv
// One SEG_W-bit subtract stage with borrow in/out and an enabled output register.
// Result registers only load on a valid beat, so bubbles leave the last result in place.
module sub_seg
    import wide_arith_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             bin_i,
    output logic             valid_o,
    output logic [SEG_W-1:0] diff_o,
    output logic             bout_o
);

    logic [SEG_W:0]   res_d;
    logic             valid_q;
    logic [SEG_W-1:0] diff_q;
    logic             bout_q;

    assign res_d = sub_seg_f(a_i, b_i, bin_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                diff_q <= res_d[SEG_W-1:0];
                bout_q <= res_d[SEG_W];
            end
        end
    end

    assign valid_o = valid_q;
    assign diff_o  = diff_q;
    assign bout_o  = bout_q;

endmodule

// File: rtl/wide_sub_96.sv
// Pipelined 96-bit unsigned subtractor with valid/ready flow control:
// S1 operand regs, S2 low-segment subtract, S3 high-segment subtract with registered borrow.
module wide_sub_96
    import wide_arith_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] dinb,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W:0]   dout
);

    // Handshake: a beat moves on valid && ready; each stage loads when the stage
    // after it is empty or draining, so bubbles collapse under backpressure.
    logic             en1, en2, en3;

    logic [DATA_W-1:0] a1_q, b1_q;
    logic              v1_q;
    logic [SEG_W-1:0]  ahi2_q, bhi2_q;
    logic [SEG_W-1:0]  lo2_diff;
    logic              lo2_bout;
    logic              v2;
    logic [SEG_W-1:0]  lo3_q;
    logic [SEG_W-1:0]  hi3_diff;
    logic              hi3_bout;
    logic              v3;

    assign en3     = !v3 || m_ready;
    assign en2     = !v2 || en3;
    assign en1     = !v1_q || en2;
    assign s_ready = en1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            a1_q <= '0;
            b1_q <= '0;
        end else if (en1) begin
            v1_q <= s_valid;
            if (s_valid) begin
                a1_q <= dina;
                b1_q <= dinb;
            end
        end
    end

    sub_seg u_lo (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en2),
        .valid_i (v1_q),
        .a_i     (a1_q[SEG_W-1:0]),
        .b_i     (b1_q[SEG_W-1:0]),
        .bin_i   (1'b0),
        .valid_o (v2),
        .diff_o  (lo2_diff),
        .bout_o  (lo2_bout)
    );

    // Upper halves ride alongside the low-segment stage untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ahi2_q <= '0;
            bhi2_q <= '0;
        end else if (en2 && v1_q) begin
            ahi2_q <= a1_q[DATA_W-1:SEG_W];
            bhi2_q <= b1_q[DATA_W-1:SEG_W];
        end
    end

    sub_seg u_hi (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en3),
        .valid_i (v2),
        .a_i     (ahi2_q),
        .b_i     (bhi2_q),
        .bin_i   (lo2_bout),
        .valid_o (v3),
        .diff_o  (hi3_diff),
        .bout_o  (hi3_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo3_q <= '0;
        end else if (en3 && v2) begin
            lo3_q <= lo2_diff;
        end
    end

    assign m_valid = v3;
    assign dout    = {hi3_bout, hi3_diff, lo3_q};

endmodule

// File: tb/tb_wide_sub_96.sv
// Self-checking bench for wide_sub_96: directed vector table, latency, backpressure,
// random bubbles and mid-stream reset, all checked through an expected-result queue.
module tb_wide_sub_96;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [95:0]  dina = '0;
    logic [95:0]  dinb = '0;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [96:0]  dout;

    int           checks = 0;
    int           errors = 0;
    int           ready_mode = 0; // 0: ready high, 1: ready low, 2: random
    logic [96:0]  exp_q[$];

    typedef struct {
        string       name;
        logic [95:0] a;
        logic [95:0] b;
        logic [96:0] exp;
    } vec_t;

    vec_t vecs[10];

    wide_sub_96 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .dina    (dina),
        .dinb    (dinb),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .dout    (dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [96:0] act, input logic [96:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result got=%h expected=none", dout);
            end else begin
                check("result", dout, exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [95:0] a, input logic [95:0] b, input logic [96:0] exp);
        int waited;
        waited = 0;
        exp_q.push_back(exp);
        dina    = a;
        dinb    = b;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout got=%0d expected=%0d", waited, 200);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check(name, 97'(exp_q.size()), 97'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [95:0] ra, rb;
        int          saw_block;
        int          stale;

        vecs[0] = '{"small",       96'h5, 96'h3, 97'h2};
        vecs[1] = '{"lo_borrow",   96'h000000000001_000000000000, 96'h1,
                    {1'b0, 96'h000000000000_FFFFFFFFFFFF}};
        vecs[2] = '{"zero_minus1", 96'h0, 96'h1, {1'b1, {96{1'b1}}}};
        vecs[3] = '{"equal",       96'h123456789ABCDEF012345678, 96'h123456789ABCDEF012345678, 97'h0};
        vecs[4] = '{"max_minus0",  {96{1'b1}}, 96'h0, {1'b0, {96{1'b1}}}};
        vecs[5] = '{"zero_minmax", 96'h0, {96{1'b1}}, {1'b1, 96'h1}};
        vecs[6] = '{"both_halves", 96'h000000000005_000000000000, 96'h000000000002_000000000001,
                    {1'b0, 96'h000000000002_FFFFFFFFFFFF}};
        vecs[7] = '{"hi_borrow",   96'h000000000001_000000000000, 96'h000000000002_000000000000,
                    {1'b1, 96'hFFFFFFFFFFFF_000000000000}};
        vecs[8] = '{"msb_chain",   96'h800000000000_000000000000, 96'h1,
                    {1'b0, 96'h7FFFFFFFFFFF_FFFFFFFFFFFF}};
        vecs[9] = '{"dec_100_1000", 96'd100, 96'd1000, {1'b1, 96'hFFFFFFFFFFFFFFFFFFFFFC7C}};

        // Reset and post-reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_m_valid", 97'(m_valid), 97'd0);
        check("reset_dout", dout, 97'd0);
        check("reset_s_ready", 97'(s_ready), 97'd1);

        // Exact three-cycle latency on an empty pipe
        @(posedge clk);
        #1;
        exp_q.push_back(97'h2);
        dina    = 96'h5;
        dinb    = 96'h3;
        s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) check("lat_s_ready", 97'(s_ready), 97'd1);
            if (k < 3) begin
                check("lat_m_valid_low", 97'(m_valid), 97'd0);
                check("lat_dout_zero", dout, 97'd0);
            end else begin
                check("lat_m_valid_high", 97'(m_valid), 97'd1);
            end
            if (k == 0) begin
                @(posedge clk);
                #1;
                s_valid = 1'b0;
            end
        end
        wait_drain("lat_drain");

        // Directed vector table, back-to-back
        for (int i = 0; i < 10; i++) send(vecs[i].a, vecs[i].b, vecs[i].exp);
        wait_drain("table_drain");

        // Backpressure mid-stream
        saw_block = 0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(96'(i * 7 + 100), 96'(i * 3), 97'(i * 4 + 100));
            end
            begin
                repeat (4) @(posedge clk);
                ready_mode = 1;
                repeat (5) @(posedge clk);
                ready_mode = 0;
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (!s_ready) saw_block = 1;
                end
            end
        join
        wait_drain("bp_drain");
        check("bp_s_ready_dropped", 97'(saw_block), 97'd1);

        // Random pairs with bubbles and random downstream ready
        ready_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            ra = {$urandom(), $urandom(), $urandom()};
            rb = (i % 16 == 0) ? ra : {$urandom(), $urandom(), $urandom()};
            send(ra, rb, {1'b0, ra} - {1'b0, rb});
            @(posedge clk);
            #1;
        end
        wait_drain("rand_drain");

        // Reset with three results in flight
        ready_mode = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(96'(1000 + i), 96'd1, 97'(999 + i));
        @(negedge clk);
        check("inflight_m_valid", 97'(m_valid), 97'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_m_valid", 97'(m_valid), 97'd0);
        check("async_rst_dout", dout, 97'd0);
        exp_q.delete();
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_valid) stale++;
        end
        check("no_stale_results", 97'(stale), 97'd0);
        check("post_rst_s_ready", 97'(s_ready), 97'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
